// File: rtl/switch_acc_pkg.sv
// Shared types and constants for the switch accumulator.
package switch_acc_pkg;

  localparam int PRESS_CNT_W = 16;

  typedef enum logic [1:0] {
    ADD  = 2'b00,
    SUB  = 2'b01,
    LOAD = 2'b10,
    HOLD = 2'b11
  } acc_mode_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    EXEC     = 2'b01,
    WAIT_REL = 2'b10
  } acc_state_e;

endpackage

// File: rtl/button_debouncer.sv
// Synchronises a raw active-low button and accepts a new level only after
// it has been stable for DEBOUNCE_CYCLES consecutive cycles.
module button_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic key_n,
  output logic stable,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_q <= '1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
      press  <= 1'b0;
      if (synced != stable) begin
        // The accepting cycle is the DEBOUNCE_CYCLES-th mismatch in a row.
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable <= synced;
          press  <= stable & ~synced;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/switch_accumulator.sv
// Button-driven accumulator: each debounced press folds sw into acc using
// the selected mode, with wrap or saturate arithmetic and a sticky overflow.
module switch_accumulator
  import switch_acc_pkg::*;
#(
  parameter int DATA_W          = 8,
  parameter int ACC_W           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2,
  parameter bit SATURATE        = 1'b0
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [DATA_W-1:0]      sw,
  input  logic                   key_n,
  input  logic                   clear,
  input  logic [1:0]             mode,
  output logic [ACC_W-1:0]       acc,
  output logic                   ovf,
  output logic                   op_done,
  output logic [PRESS_CNT_W-1:0] press_count
);

  acc_state_e       state;
  logic             stable;
  logic             press;
  logic [ACC_W-1:0] operand;
  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   diff;
  logic [ACC_W-1:0] nxt_acc;
  logic             nxt_ovf;

  button_debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .Clk   (Clk),
    .Reset (Reset),
    .key_n (key_n),
    .stable(stable),
    .press (press)
  );

  assign operand = ACC_W'(sw);
  assign sum     = {1'b0, acc} + {1'b0, operand};
  assign diff    = {1'b0, acc} - {1'b0, operand};

  always_comb begin
    nxt_acc = acc;
    nxt_ovf = ovf;
    unique case (acc_mode_e'(mode))
      ADD: begin
        nxt_acc = (SATURATE && sum[ACC_W]) ? '1 : sum[ACC_W-1:0];
        nxt_ovf = ovf | sum[ACC_W];
      end
      SUB: begin
        nxt_acc = (SATURATE && diff[ACC_W]) ? '0 : diff[ACC_W-1:0];
        nxt_ovf = ovf | diff[ACC_W];
      end
      LOAD: nxt_acc = operand;
      HOLD: nxt_acc = acc;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      acc         <= '0;
      ovf         <= 1'b0;
      op_done     <= 1'b0;
      press_count <= '0;
    end else begin
      op_done <= 1'b0;
      case (state)
        IDLE: if (press) state <= EXEC;
        EXEC: begin
          state <= WAIT_REL;
          if (!clear) begin
            acc         <= nxt_acc;
            ovf         <= nxt_ovf;
            op_done     <= 1'b1;
            press_count <= press_count + 1'b1;
          end
        end
        WAIT_REL: if (stable) state <= IDLE;
        default:  state <= IDLE;
      endcase
      if (clear) begin
        acc <= '0;
        ovf <= 1'b0;
      end
    end
  end

endmodule
